// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//   Compares two operand words that arrive one digit pair per accepted beat
//   and reports A<B / A==B / A>B once the whole word has been seen.
//   Digits can arrive MSB-first or LSB-first. Operands can be unsigned or
//   two's-complement. Both modes are latched when start is accepted.
//
// Parameters
//   DW    digit width in bits per beat (>= 1)
//   NDIG  digits per operand word (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   start      begin (or abort and restart) a comparison; latches modes
//   signed_en  operands are two's-complement (sampled on start)
//   lsb_first  digits arrive least-significant first (sampled on start)
//   in_valid   a_dig/b_dig carry a valid digit pair
//   in_ready   digit pair is accepted this cycle (RUN state)
//   a_dig      digit of operand A
//   b_dig      digit of operand B
//   L/E/G      registered result, one-hot in DONE, all zero otherwise
//   done       one-cycle pulse when L/E/G become valid
//   busy       comparison in progress
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | after reset, waiting for start; L/E/G all zero
// S_RUN  | accepting digit pairs, relation being accumulated
// S_DONE | word complete, L/E/G hold the result until next start

module serial_magnitude_comparator #(
  parameter int DW   = 1,
  parameter int NDIG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          signed_en,
  input  logic          lsb_first,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_dig,
  input  logic [DW-1:0] b_dig,
  output logic          L,
  output logic          E,
  output logic          G,
  output logic          done,
  output logic          busy
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

  state_t        r_state;
  state_t        w_state_nxt;
  rel_t          r_rel;
  rel_t          w_rel_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_signed;
  logic          r_lsb;
  logic          r_l;
  logic          r_e;
  logic          r_g;
  logic          r_done;
  logic          w_run;
  logic          w_accept;
  logic          w_last;
  logic          w_msd;
  logic          w_dig_gt;
  logic          w_dig_ne;

  assign w_run    = (r_state == S_RUN);
  // start wins over a digit in the same cycle: the digit is dropped
  assign w_accept = w_run && in_valid && !start;
  assign w_last   = (r_cnt == LAST_BEAT);
  // most-significant digit is the first beat MSB-first, the last beat LSB-first
  assign w_msd    = r_lsb ? w_last : (r_cnt == '0);
  assign w_dig_ne = (a_dig != b_dig);

  always_comb begin
    w_dig_gt = (a_dig > b_dig);
    if (r_signed && w_msd) begin
      w_dig_gt = ($signed(a_dig) > $signed(b_dig));
    end
  end

  // MSB-first: first difference decides. LSB-first: latest difference decides.
  always_comb begin
    w_rel_nxt = r_rel;
    if (w_dig_ne && (r_lsb || (r_rel == REL_EQ))) begin
      w_rel_nxt = w_dig_gt ? REL_GT : REL_LT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else if (w_accept && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_rel    <= REL_EQ;
      r_signed <= 1'b0;
      r_lsb    <= 1'b0;
      r_l      <= 1'b0;
      r_e      <= 1'b0;
      r_g      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_cnt    <= '0;
        r_rel    <= REL_EQ;
        r_signed <= signed_en;
        r_lsb    <= lsb_first;
        r_l      <= 1'b0;
        r_e      <= 1'b0;
        r_g      <= 1'b0;
      end else if (w_accept) begin
        r_rel <= w_rel_nxt;
        if (w_last) begin
          r_cnt  <= '0;
          r_l    <= (w_rel_nxt == REL_LT);
          r_e    <= (w_rel_nxt == REL_EQ);
          r_g    <= (w_rel_nxt == REL_GT);
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign in_ready = w_run;
  assign busy     = w_run;
  assign L        = r_l;
  assign E        = r_e;
  assign G        = r_g;
  assign done     = r_done;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Testbench for serial_magnitude_comparator.
// Three instances share the digit/mode/in_valid buses and each has its own start:
//   dut0: DW=1 NDIG=8, dut1: DW=4 NDIG=2, dut2: DW=2 NDIG=1.
// Expected results come from a whole-word integer compare of the operands.

module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic       signed_en;
  logic       lsb_first;
  logic       in_valid;
  logic [3:0] a_bus;
  logic [3:0] b_bus;
  logic [2:0] rdy_v, l_v, e_v, g_v, done_v, busy_v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.DW(1), .NDIG(8)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .signed_en(signed_en),
    .lsb_first(lsb_first), .in_valid(in_valid), .in_ready(rdy_v[0]),
    .a_dig(a_bus[0:0]), .b_dig(b_bus[0:0]), .L(l_v[0]), .E(e_v[0]),
    .G(g_v[0]), .done(done_v[0]), .busy(busy_v[0]));

  serial_magnitude_comparator #(.DW(4), .NDIG(2)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .signed_en(signed_en),
    .lsb_first(lsb_first), .in_valid(in_valid), .in_ready(rdy_v[1]),
    .a_dig(a_bus[3:0]), .b_dig(b_bus[3:0]), .L(l_v[1]), .E(e_v[1]),
    .G(g_v[1]), .done(done_v[1]), .busy(busy_v[1]));

  serial_magnitude_comparator #(.DW(2), .NDIG(1)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .signed_en(signed_en),
    .lsb_first(lsb_first), .in_valid(in_valid), .in_ready(rdy_v[2]),
    .a_dig(a_bus[1:0]), .b_dig(b_bus[1:0]), .L(l_v[2]), .E(e_v[2]),
    .G(g_v[2]), .done(done_v[2]), .busy(busy_v[2]));

  function automatic int dw_of(input int idx);
    case (idx)
      0: return 1;
      1: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int ndig_of(input int idx);
    case (idx)
      0: return 8;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  // {busy, in_ready, done, L, E, G}
  function automatic logic [5:0] stat(input int idx);
    return {busy_v[idx], rdy_v[idx], done_v[idx], l_v[idx], e_v[idx], g_v[idx]};
  endfunction

  // reference: compare the full words as integers, returns {L,E,G}
  function automatic logic [2:0] ref_leg(input int idx, input logic [7:0] a,
                                         input logic [7:0] b, input logic sgn);
    int     w;
    longint msk, va, vb;
    w   = dw_of(idx) * ndig_of(idx);
    msk = (longint'(1) << w) - 1;
    va  = longint'(a) & msk;
    vb  = longint'(b) & msk;
    if (sgn && va[w-1]) va = va - (msk + 1);
    if (sgn && vb[w-1]) vb = vb - (msk + 1);
    if (va < vb) return 3'b100;
    if (va == vb) return 3'b010;
    return 3'b001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a full word on one instance. stall >= 0: fixed idle cycles between
  // beats; stall < 0: random 0..2 idle cycles before each beat.
  // junk=1 presents a valid digit in the start cycle, which must be dropped.
  task automatic do_word(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic sgn, input logic lsb, input int stall,
                         input logic junk, input string tag);
    int         dw, nd, k, ns;
    logic [2:0] exp_leg;
    logic [7:0] m;
    logic [5:0] got;
    dw      = dw_of(idx);
    nd      = ndig_of(idx);
    exp_leg = ref_leg(idx, a, b, sgn);
    m       = 8'((1 << dw) - 1);
    start_v[idx] = 1'b1;
    signed_en    = sgn;
    lsb_first    = lsb;
    in_valid     = junk;
    a_bus        = 4'($urandom);
    b_bus        = 4'($urandom);
    tick();
    start_v   = '0;
    in_valid  = 1'b0;
    signed_en = 1'($urandom);
    lsb_first = 1'($urandom);
    got = stat(idx);
    n_cmp++;
    if (got !== 6'b110000) begin
      n_bad++;
      $display("FAIL %s start: dut%0d {busy,rdy,done,L,E,G}=%b required %b", tag, idx, got, 6'b110000);
    end
    for (int i = 0; i < nd; i++) begin
      ns = (stall >= 0) ? ((i > 0) ? stall : 0) : int'($urandom_range(0, 2));
      for (int s = 0; s < ns; s++) begin
        in_valid = 1'b0;
        a_bus    = 4'($urandom);
        b_bus    = 4'($urandom);
        tick();
        got = stat(idx);
        n_cmp++;
        if (got !== 6'b110000) begin
          n_bad++;
          $display("FAIL %s stall beat %0d: dut%0d {busy,rdy,done,L,E,G}=%b required %b", tag, i, idx, got, 6'b110000);
        end
      end
      k        = lsb ? i : nd - 1 - i;
      a_bus    = 4'((a >> (k * dw)) & m);
      b_bus    = 4'((b >> (k * dw)) & m);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      got = stat(idx);
      n_cmp++;
      if (i < nd - 1) begin
        if (got !== 6'b110000) begin
          n_bad++;
          $display("FAIL %s beat %0d: dut%0d {busy,rdy,done,L,E,G}=%b required %b", tag, i, idx, got, 6'b110000);
        end
      end else begin
        if (got !== {3'b001, exp_leg}) begin
          n_bad++;
          $display("FAIL %s result: dut%0d a=%h b=%h {busy,rdy,done,L,E,G}=%b required %b", tag, idx, a, b, got, {3'b001, exp_leg});
        end
      end
    end
    tick();
    got = stat(idx);
    n_cmp++;
    if (got !== {3'b000, exp_leg}) begin
      n_bad++;
      $display("FAIL %s hold: dut%0d {busy,rdy,done,L,E,G}=%b required %b", tag, idx, got, {3'b000, exp_leg});
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      got = stat(d);
      n_cmp++;
      if (got !== 6'b000000) begin
        n_bad++;
        $display("FAIL reset_state: dut%0d {busy,rdy,done,L,E,G}=%b required 000000", d, got);
      end
    end
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a_bus    = 4'($urandom);
      b_bus    = 4'($urandom);
      tick();
      for (int d = 0; d < 3; d++) begin
        got = stat(d);
        n_cmp++;
        if (got !== 6'b000000) begin
          n_bad++;
          $display("FAIL idle_after_reset: dut%0d {busy,rdy,done,L,E,G}=%b required 000000", d, got);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_directed();
    do_word(0, 8'h5A, 8'h5C, 1'b0, 1'b0, 0, 1'b0, "msb_unsigned_5a_5c");
    do_word(0, 8'h80, 8'h01, 1'b1, 1'b0, 0, 1'b0, "msb_signed_80_01");
    do_word(0, 8'h80, 8'h01, 1'b0, 1'b0, 0, 1'b0, "msb_unsigned_80_01");
    do_word(0, 8'h01, 8'h10, 1'b0, 1'b1, 0, 1'b0, "lsb_unsigned_01_10");
    do_word(0, 8'hA5, 8'hA5, 1'b0, 1'b1, 0, 1'b0, "lsb_equal_a5");
    do_word(0, 8'h7F, 8'h80, 1'b1, 1'b1, 0, 1'b0, "lsb_signed_7f_80");
    do_word(1, 8'hF3, 8'h0E, 1'b1, 1'b0, 3, 1'b0, "dw4_signed_stall");
    do_word(1, 8'h3F, 8'h3E, 1'b1, 1'b1, 2, 1'b0, "dw4_lsb_low_digit");
  endtask

  task automatic test_ndig1();
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int s = 0; s < 2; s++) begin
          do_word(2, 8'(a), 8'(b), 1'(s), 1'($urandom), -1, 1'($urandom), "ndig1");
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic       sgn;
    logic [2:0] exp_leg;
    logic [5:0] got;
    for (int n = 0; n < 6; n++) begin
      a   = 8'($urandom);
      b   = (n % 3 == 0) ? a : 8'($urandom);
      sgn = 1'($urandom);
      do_word(0, a, b, sgn, 1'($urandom), 0, 1'b1, "back_to_back");
    end
    exp_leg = ref_leg(0, a, b, sgn);
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'($urandom);
      a_bus    = 4'($urandom);
      b_bus    = 4'($urandom);
      tick();
      got = stat(0);
      n_cmp++;
      if (got !== {3'b000, exp_leg}) begin
        n_bad++;
        $display("FAIL done_hold: dut0 {busy,rdy,done,L,E,G}=%b required %b", got, {3'b000, exp_leg});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic partial_word(input int beats, input string tag);
    logic [7:0] a, b;
    logic [5:0] got;
    a = 8'h5A;
    b = 8'h5C;
    start_v[0] = 1'b1;
    signed_en  = 1'b0;
    lsb_first  = 1'b0;
    in_valid   = 1'b0;
    tick();
    start_v = '0;
    for (int i = 0; i < beats; i++) begin
      a_bus    = 4'(a[7-i]);
      b_bus    = 4'(b[7-i]);
      in_valid = 1'b1;
      tick();
      got = stat(0);
      n_cmp++;
      if (got !== 6'b110000) begin
        n_bad++;
        $display("FAIL %s beat %0d: dut0 {busy,rdy,done,L,E,G}=%b required 110000", tag, i, got);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    logic [5:0] got;
    partial_word(5, "abort_partial");
    do_word(0, 8'h33, 8'h33, 1'b0, 1'b0, 0, 1'b1, "abort_restart");
    partial_word(4, "reset_partial");
    #2;
    rst = 1'b0;
    #1;
    got = stat(0);
    n_cmp++;
    if (got !== 6'b000000) begin
      n_bad++;
      $display("FAIL async_reset: dut0 {busy,rdy,done,L,E,G}=%b required 000000", got);
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      a_bus    = 4'($urandom);
      b_bus    = 4'($urandom);
      tick();
      got = stat(0);
      n_cmp++;
      if (got !== 6'b000000) begin
        n_bad++;
        $display("FAIL post_reset_idle: dut0 {busy,rdy,done,L,E,G}=%b required 000000", got);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    int         idx;
    logic [7:0] a, b;
    for (int n = 0; n < 60; n++) begin
      idx = int'($urandom_range(0, 2));
      a   = 8'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      do_word(idx, a, b, 1'($urandom), 1'($urandom), -1, 1'($urandom), "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start_v   = '0;
    signed_en = 1'b0;
    lsb_first = 1'b0;
    in_valid  = 1'b0;
    a_bus     = '0;
    b_bus     = '0;
    test_reset();
    test_directed();
    test_ndig1();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
